// File: rtl/direction_ctrl_if.sv
// Bundle between the direction controller and its surroundings: the raw button, the
// auto-reverse enable and the fed-back counter value go in; the direction level, the
// debounced button level and the press pulse come out.
//   master : drives btn_raw, auto_rev, count; observes up_down, btn_level, press_pulse
//   slave  : the direction_ctrl side of the same signals
interface direction_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             btn_raw;
    logic             auto_rev;
    logic [WIDTH-1:0] count;
    logic             up_down;
    logic             btn_level;
    logic             press_pulse;

    modport master (
        output btn_raw,
        output auto_rev,
        output count,
        input  up_down,
        input  btn_level,
        input  press_pulse
    );

    modport slave (
        input  btn_raw,
        input  auto_rev,
        input  count,
        output up_down,
        output btn_level,
        output press_pulse
    );
endinterface

// File: rtl/direction_ctrl.sv
// Direction control stage for an up/down counter. Synchronises and debounces a raw
// push-button, toggles the count direction on every accepted press and, when
// auto-reverse is enabled, flips direction one value before each end point so the
// attached counter ping-pongs without ever wrapping.
//   clk      : system clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset
//   ctrl_io  : btn_raw, auto_rev, count in; up_down, btn_level, press_pulse out
module direction_ctrl #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          UP_RESET        = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    direction_ctrl_if.slave ctrl_io
);

    localparam int unsigned      CntW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0]  DbLast   = CntW'(DEBOUNCE_CYCLES - 1);
    // The counter moves on the same edge we switch direction, so compare one step early.
    localparam logic [WIDTH-1:0] CntTopM1 = {WIDTH{1'b1}} - WIDTH'(1);
    localparam logic [WIDTH-1:0] CntOne   = WIDTH'(1);

    typedef enum logic [0:0] {
        StDown = 1'b0,
        StUp   = 1'b1
    } dir_e;

    localparam dir_e DirReset = UP_RESET ? StUp : StDown;

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] db_cnt_q, db_cnt_d;
    logic            btn_level_q, btn_level_d;
    logic            press_pulse_q, press_pulse_d;
    dir_e            dir_q, dir_d;

    // Two-flop synchroniser, nothing in front of the second flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ctrl_io.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive cycles the synced button differs from the accepted
    // level; any cycle that agrees restarts the count.
    always_comb begin
        db_cnt_d    = db_cnt_q;
        btn_level_d = btn_level_q;
        if (sync2_q == btn_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            btn_level_d = sync2_q;
            db_cnt_d    = '0;
        end else begin
            db_cnt_d = db_cnt_q + CntW'(1);
        end
        press_pulse_d = btn_level_d & ~btn_level_q;
    end

    // Direction FSM: a press always wins over an end-point reversal.
    always_comb begin
        dir_d = dir_q;
        unique case (dir_q)
            StUp: begin
                if (press_pulse_d) begin
                    dir_d = StDown;
                end else if (ctrl_io.auto_rev && (ctrl_io.count == CntTopM1)) begin
                    dir_d = StDown;
                end
            end
            StDown: begin
                if (press_pulse_d) begin
                    dir_d = StUp;
                end else if (ctrl_io.auto_rev && (ctrl_io.count == CntOne)) begin
                    dir_d = StUp;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_q      <= '0;
            btn_level_q   <= 1'b0;
            press_pulse_q <= 1'b0;
            dir_q         <= DirReset;
        end else begin
            db_cnt_q      <= db_cnt_d;
            btn_level_q   <= btn_level_d;
            press_pulse_q <= press_pulse_d;
            dir_q         <= dir_d;
        end
    end

    assign ctrl_io.up_down     = (dir_q == StUp);
    assign ctrl_io.btn_level   = btn_level_q;
    assign ctrl_io.press_pulse = press_pulse_q;

endmodule
